// File: rtl/counter_updown_mod_pkg.sv
// Shared constants and elaboration helpers for the up/down modulo counter family.
package counter_updown_mod_pkg;

   localparam int MODE_WRAP = 0;
   localparam int MODE_SAT  = 1;

   function automatic int clog2(input longint unsigned val);
      int r;
      longint unsigned v;
      r = 0;
      v = 64'd1;
      for (int i = 0; i < 64; i++) begin
         if (v < val) begin
            v = v << 1;
            r = r + 1;
         end
      end
      return r;
   endfunction

   function automatic bit max_val_ok(input int width, input longint unsigned max_val);
      return (width >= 1) && (width <= 32) && (max_val < (64'd1 << width));
   endfunction

endpackage

// File: rtl/counter_updown_mod_prescaler_tick.sv
// Prescaler: emits one tick every PRESCALE qualified enables; the first qualified enable after reset ticks.
module prescaler_tick
   import counter_updown_mod_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic CLK,
   input  logic RES,
   input  logic q,
   input  logic reload,
   output logic tick
);

   localparam int PW = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
   localparam logic [PW-1:0] LP_RELOAD = PW'(PRESCALE - 1);

   if ((PRESCALE < 1) || (PRESCALE > 65535)) begin : g_bad_prescale
      $fatal(1, "prescaler_tick: PRESCALE out of range 1..65535");
   end

   logic [PW-1:0] r_cnt;
   logic          w_zero;

   assign w_zero = (r_cnt == '0);
   assign tick   = q & w_zero;

   always_ff @(posedge CLK or posedge RES) begin
      if (RES) begin
         r_cnt <= '0;
      end else if (reload) begin
         r_cnt <= LP_RELOAD;
      end else if (q) begin
         r_cnt <= w_zero ? LP_RELOAD : (r_cnt - PW'(1));
      end
   end

endmodule

// File: rtl/counter_updown_mod.sv
// Parametrised up/down modulo counter with load, clear, wrap/saturate mode, prescaler and cascade chain.
module counter_updown_mod
   import counter_updown_mod_pkg::*;
#(
   parameter int              WIDTH    = 16,
   parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
   parameter int              MODE     = MODE_WRAP,
   parameter int              PRESCALE = 1
) (
   input  logic             CLK,
   input  logic             RES,
   input  logic             EN,
   input  logic             CIN,
   input  logic             UP,
   input  logic             CLR,
   input  logic             LOAD,
   input  logic [WIDTH-1:0] LOAD_VAL,
   output logic [WIDTH-1:0] countVal,
   output logic             COUT,
   output logic             TC,
   output logic             EVT
);

   if (!max_val_ok(WIDTH, MAX_VAL)) begin : g_bad_max
      $fatal(1, "counter_updown_mod: MAX_VAL must be below 2**WIDTH, WIDTH in 1..32");
   end

   localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MAX_VAL);

   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] w_next;
   logic             r_evt;
   logic             w_q;
   logic             w_reload;
   logic             w_tick;
   logic             w_at_max;
   logic             w_at_zero;

   assign w_q       = EN & CIN;
   assign w_reload  = CLR | LOAD;
   assign w_at_max  = (r_count == LP_MAX);
   assign w_at_zero = (r_count == '0);

   prescaler_tick #(
      .PRESCALE(PRESCALE)
   ) u_prescaler (
      .CLK   (CLK),
      .RES   (RES),
      .q     (w_q),
      .reload(w_reload),
      .tick  (w_tick)
   );

   assign TC       = (UP & w_at_max) | (~UP & w_at_zero);
   assign COUT     = TC & w_tick;
   assign countVal = r_count;
   assign EVT      = r_evt;

   // CLR beats LOAD beats step; a boundary step either wraps or holds depending on MODE
   always_comb begin
      w_next = r_count;
      if (CLR) begin
         w_next = '0;
      end else if (LOAD) begin
         w_next = (LOAD_VAL > LP_MAX) ? LP_MAX : LOAD_VAL;
      end else if (w_tick) begin
         if (UP) begin
            if (!w_at_max) begin
               w_next = r_count + WIDTH'(1);
            end else if (MODE == MODE_WRAP) begin
               w_next = '0;
            end
         end else begin
            if (!w_at_zero) begin
               w_next = r_count - WIDTH'(1);
            end else if (MODE == MODE_WRAP) begin
               w_next = LP_MAX;
            end
         end
      end
   end

   always_ff @(posedge CLK or posedge RES) begin
      if (RES) begin
         r_count <= '0;
         r_evt   <= 1'b0;
      end else begin
         r_count <= w_next;
         r_evt   <= w_reload ? 1'b0 : (w_tick & TC);
      end
   end

endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed bench: wrap, saturate, load/clear priority, prescaler and a two-digit cascade.
module tb_counter_updown_mod;
   import counter_updown_mod_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // wrap instance
   logic       w_res, w_en, w_up, w_clr, w_load;
   logic [3:0] w_lv, w_cnt;
   logic       w_cout, w_tc, w_evt;
   // saturate instance
   logic       s_res, s_en, s_up, s_clr, s_load;
   logic [3:0] s_lv, s_cnt;
   logic       s_cout, s_tc, s_evt;
   // prescaled instance
   logic       p_res, p_en, p_up, p_clr, p_load;
   logic [3:0] p_lv, p_cnt;
   logic       p_cout, p_tc, p_evt;
   // cascade pair
   logic       c_res, c_en;
   logic [3:0] lo_cnt, hi_cnt;
   logic       lo_cout, hi_cout, lo_tc, hi_tc, lo_evt, hi_evt;
   logic [3:0] c_zero = 4'd0;

   counter_updown_mod #(.WIDTH(4), .MAX_VAL(9), .MODE(MODE_WRAP), .PRESCALE(1)) dut_w (
      .CLK(clk), .RES(w_res), .EN(w_en), .CIN(1'b1), .UP(w_up), .CLR(w_clr), .LOAD(w_load),
      .LOAD_VAL(w_lv), .countVal(w_cnt), .COUT(w_cout), .TC(w_tc), .EVT(w_evt));

   counter_updown_mod #(.WIDTH(4), .MAX_VAL(9), .MODE(MODE_SAT), .PRESCALE(1)) dut_s (
      .CLK(clk), .RES(s_res), .EN(s_en), .CIN(1'b1), .UP(s_up), .CLR(s_clr), .LOAD(s_load),
      .LOAD_VAL(s_lv), .countVal(s_cnt), .COUT(s_cout), .TC(s_tc), .EVT(s_evt));

   counter_updown_mod #(.WIDTH(4), .MAX_VAL(9), .MODE(MODE_WRAP), .PRESCALE(3)) dut_p (
      .CLK(clk), .RES(p_res), .EN(p_en), .CIN(1'b1), .UP(p_up), .CLR(p_clr), .LOAD(p_load),
      .LOAD_VAL(p_lv), .countVal(p_cnt), .COUT(p_cout), .TC(p_tc), .EVT(p_evt));

   counter_updown_mod #(.WIDTH(4), .MAX_VAL(9), .MODE(MODE_WRAP), .PRESCALE(1)) dut_lo (
      .CLK(clk), .RES(c_res), .EN(c_en), .CIN(1'b1), .UP(1'b1), .CLR(1'b0), .LOAD(1'b0),
      .LOAD_VAL(c_zero), .countVal(lo_cnt), .COUT(lo_cout), .TC(lo_tc), .EVT(lo_evt));

   counter_updown_mod #(.WIDTH(4), .MAX_VAL(9), .MODE(MODE_WRAP), .PRESCALE(1)) dut_hi (
      .CLK(clk), .RES(c_res), .EN(c_en), .CIN(lo_cout), .UP(1'b1), .CLR(1'b0), .LOAD(1'b0),
      .LOAD_VAL(c_zero), .countVal(hi_cnt), .COUT(hi_cout), .TC(hi_tc), .EVT(hi_evt));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      w_res = 1; w_en = 0; w_up = 1; w_clr = 0; w_load = 0; w_lv = 0;
      s_res = 1; s_en = 0; s_up = 1; s_clr = 0; s_load = 0; s_lv = 0;
      p_res = 1; p_en = 0; p_up = 1; p_clr = 0; p_load = 0; p_lv = 0;
      c_res = 1; c_en = 0;
      #3;
      chk("rst_w_cnt", w_cnt, 0);
      chk("rst_w_evt", w_evt, 0);
      chk("rst_w_tc_up", w_tc, 0);
      chk("rst_p_cnt", p_cnt, 0);
      #9;
      w_res = 0; s_res = 0; p_res = 0; c_res = 0;

      // wrap, counting up
      w_en = 1;
      for (int i = 1; i <= 12; i++) begin
         step();
         chk("wrap_up_cnt", w_cnt, i % 10);
         chk("wrap_up_evt", w_evt, (i == 10) ? 1 : 0);
         chk("wrap_up_tc", w_tc, ((i % 10) == 9) ? 1 : 0);
         chk("wrap_up_cout", w_cout, ((i % 10) == 9) ? 1 : 0);
      end

      // wrap, counting down from 0
      w_clr = 1;
      step();
      chk("clr_cnt", w_cnt, 0);
      chk("clr_evt", w_evt, 0);
      w_clr = 0; w_up = 0;
      #1;
      chk("down_tc_at0", w_tc, 1);
      chk("down_cout_at0", w_cout, 1);
      for (int i = 1; i <= 3; i++) begin
         step();
         chk("wrap_dn_cnt", w_cnt, 10 - i);
         chk("wrap_dn_evt", w_evt, (i == 1) ? 1 : 0);
         chk("wrap_dn_tc", w_tc, 0);
      end

      // load clamp, load beating a tick, clear beating load
      w_en = 0; w_load = 1; w_lv = 4'd14;
      step();
      chk("load_clamp", w_cnt, 9);
      chk("load_clamp_evt", w_evt, 0);
      w_en = 1; w_up = 1; w_lv = 4'd3;
      #1;
      chk("load_tick_cout", w_cout, 1);
      step();
      chk("load_wins_cnt", w_cnt, 3);
      chk("load_wins_evt", w_evt, 0);
      w_clr = 1; w_lv = 4'd5;
      step();
      chk("clr_over_load", w_cnt, 0);
      w_clr = 0; w_load = 0; w_en = 0;

      // saturate up
      s_en = 1;
      for (int i = 1; i <= 15; i++) begin
         step();
         chk("sat_up_cnt", s_cnt, (i < 9) ? i : 9);
         chk("sat_up_evt", s_evt, (i >= 10) ? 1 : 0);
      end
      s_clr = 1;
      step();
      chk("sat_clr", s_cnt, 0);
      s_clr = 0; s_up = 0;
      step();
      chk("sat_dn_hold", s_cnt, 0);
      chk("sat_dn_evt", s_evt, 1);
      s_en = 0;
      step();
      chk("sat_evt_drop", s_evt, 0);

      // prescale by 3
      p_en = 1;
      for (int i = 1; i <= 9; i++) begin
         step();
         chk("pre_cnt", p_cnt, (i + 2) / 3);
      end
      p_en = 0; p_clr = 1;
      step();
      chk("pre_clr", p_cnt, 0);
      p_clr = 0;
      p_en = 1; step(); chk("pre_q1", p_cnt, 0);
      p_en = 0; step(); chk("pre_q0", p_cnt, 0);
      p_en = 1; step(); chk("pre_q2", p_cnt, 0);
      step();           chk("pre_q3", p_cnt, 1);
      step();           chk("pre_partial", p_cnt, 1);
      #2; p_res = 1; #1;
      chk("pre_async_rst", p_cnt, 0);
      p_res = 0;
      step();
      chk("pre_after_rst", p_cnt, 1);
      p_en = 0;

      // two-digit cascade
      c_en = 1;
      for (int i = 1; i <= 47; i++) step();
      chk("casc47", {hi_cnt, lo_cnt}, 8'h47);
      #2; c_res = 1; #1;
      chk("casc_async_rst", {hi_cnt, lo_cnt}, 8'h00);
      c_res = 0;
      for (int i = 1; i <= 99; i++) step();
      chk("casc99", {hi_cnt, lo_cnt}, 8'h99);
      chk("casc99_cout", {hi_cout, lo_cout}, 2'b11);
      step();
      chk("casc100", {hi_cnt, lo_cnt}, 8'h00);
      chk("casc100_evt", {hi_evt, lo_evt}, 2'b11);
      c_en = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/counter_updown_mod.md
Name: counter_updown_mod

Overview:
- Parametrised up/down modulo counter: successor to the fixed-width T-flip-flop and +1 counters.
- Adds programmable width, modulus, direction, parallel load, synchronous clear, a wrap/saturate mode and an optional prescaler.
- Cascade-capable: a CIN/COUT enable chain lets several instances form longer counters.
- Used for timers, BCD digit chains and event counting on the board designs.

Parameters:
- WIDTH, 16, counter bit width (1..32).
- MAX_VAL, 2**WIDTH-1, terminal value; count range is 0..MAX_VAL.
- MODE, MODE_WRAP, MODE_WRAP (roll over) or MODE_SAT (hold at limit).
- PRESCALE, 1, number of qualified enables per count step (1..65535; 1 = no prescale).

Ports:
- CLK  in  1  rising-edge clock.
- RES  in  1  asynchronous active-high reset.
- EN  in  1  count enable.
- CIN  in  1  cascade enable from the lower stage; tie 1 when unused.
- UP  in  1  direction: 1 = increment, 0 = decrement.
- CLR  in  1  synchronous clear to 0.
- LOAD  in  1  synchronous parallel load.
- LOAD_VAL  in  WIDTH  load value.
- countVal  out  WIDTH  registered count.
- COUT  out  1  cascade enable to the upper stage (combinational).
- TC  out  1  terminal-count flag (combinational).
- EVT  out  1  registered one-cycle pulse on a wrap or saturation hit.

Behaviour:
- Reset: RES high asynchronously forces countVal=0, prescaler=0, EVT=0. Release is synchronous to CLK with no extra latency.
- Qualified enable: q = EN & CIN.
- Prescaler: PRESCALE-1 down-counter, width clog2(PRESCALE), minimum 1.
  - Advances only when q=1.
  - Issues tick=1 in the cycle it reads 0 with q=1, then reloads PRESCALE-1.
  - With PRESCALE=1, tick = q.
- Priority per rising edge: CLR > LOAD > step.
  - CLR: countVal<=0; prescaler reloads; EVT<=0.
  - LOAD: countVal<=min(LOAD_VAL, MAX_VAL); prescaler reloads; EVT<=0.
  - Step (tick=1, no CLR/LOAD), UP=1:
    - count<MAX_VAL: count+1.
    - count==MAX_VAL, MODE_WRAP: 0.
    - count==MAX_VAL, MODE_SAT: hold.
  - Step (tick=1, no CLR/LOAD), UP=0:
    - count>0: count-1.
    - count==0, MODE_WRAP: MAX_VAL.
    - count==0, MODE_SAT: hold.
  - No tick and no CLR/LOAD: hold.
- TC = (UP & countVal==MAX_VAL) | (~UP & countVal==0). Independent of enable.
- COUT = TC & tick. Chaining COUT into the next stage's CIN, with identical CLK/RES and PRESCALE=1 on upper stages, yields a multi-digit counter. Single-cycle zero-latency ripple, same as the existing T-FF chain.
- EVT: asserted the cycle after any step taken while TC=1 (a wrap, or a blocked saturation step); otherwise 0. Never held high two cycles unless consecutive TC steps occur.
- Direction change takes effect on the next step; no state is kept across a change.
- Arithmetic is WIDTH-bit unsigned; MAX_VAL < 2**WIDTH is checked at elaboration (fatal if violated).
- LOAD_VAL above MAX_VAL is clamped, never wrapped.
- A LOAD or CLR in the same cycle as a tick suppresses that step. COUT still reflects the pre-edge TC & tick.
- RES asserted mid-prescale discards the partial prescale count.

Decomposition:
- counter_pkg:
  - mode constants MODE_WRAP=0, MODE_SAT=1.
  - clog2 function.
  - shared elaboration check on MAX_VAL.
- Sub-module prescaler_tick (params PRESCALE; ports CLK, RES, q, reload -> tick). Reused by future timer blocks.
- Main module holds the count register, next-state mux, TC/COUT logic and the EVT register.

Test Plan:
- WIDTH=4, MAX_VAL=9, WRAP, UP=1, EN=1, 12 clocks from reset -> countVal 1..9,0,1,2; TC=1 at 9; EVT high the cycle count shows 0.
- Same config, UP=0 from 0 -> countVal 9,8,…; EVT pulse after 0->9; TC=1 while count=0.
- MODE_SAT, MAX_VAL=9, UP=1, 15 clocks -> countVal sticks at 9; EVT high every cycle after reaching 9 while EN=1.
- LOAD_VAL=14 with MAX_VAL=9 -> countVal=9. Then CLR and LOAD together -> 0. Then LOAD with EN and tick -> LOAD_VAL wins, no step.
- PRESCALE=3, EN=1 for 9 clocks -> countVal steps to 3; EN toggled 1,0,1,1 -> a step only on the third qualified cycle.
- Two instances, WIDTH=4, MAX_VAL=9, COUT->CIN, 100 clocks -> {hi,lo} reads 00 (wrapped 99->00). Assert RES mid-run at count 47 -> both 0 immediately, no CLK edge needed.
